condicionador_botoes: RTL and testbench



---
 rtl/condicionador_botoes.sv | 202 ++++++++++++++++++++
 tb/tb_condicionador_botoes.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
//
// Front end of the 0-99 stock counter. Two raw pushbuttons (add item /
// remove item) are synchronised, debounced and turned into a single-cycle
// step pulse plus a direction level for the counter. A small FSM makes sure
// the direction is settled one cycle before the pulse and held while the
// pulse is high, so every accepted press yields exactly one counter step.
//
// Optional feature (compile-time macro AUTO_REPEAT_EN):
//   When defined, holding a single button keeps stepping the counter:
//   the first repeat comes REPEAT_DELAY cycles after the first pulse falls,
//   then one pulse every REPEAT_PERIOD cycles. Pressing the other button
//   stops repetition until both buttons are released.
//   When undefined, each press produces one pulse and the repeat logic is
//   not built.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive synchronised samples of a new level needed
//                    before the debounced level flips (>= 2)
//   REPEAT_DELAY     cycles from the first pulse falling to the first repeat
//   REPEAT_PERIOD    cycles between repeat pulse rising edges (>= 3)
//
// Ports:
//   clock    in   system clock, rising-edge active
//   reset    in   synchronous, active-high reset
//   btn_inc  in   raw add-item button (asynchronous, active-high)
//   btn_dec  in   raw remove-item button (asynchronous, active-high)
//   pulso    out  registered step pulse, one cycle high per step
//   i        out  registered direction (1 = increment, 0 = decrement)
//   ocupado  out  registered, high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module condicionador_botoes #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_inc,
    input  logic btn_dec,
    output logic pulso,
    output logic i,
    output logic ocupado
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } estado_t;

    estado_t estado;

    // Bit 0 carries the add-item button, bit 1 the remove-item button.
    logic [1:0] botao_raw;
    logic [1:0] sync_p0;
    logic [1:0] sync_p1;
    logic [1:0] deb;
    logic [DB_W-1:0] db_cnt [2];

    assign botao_raw = {btn_dec, btn_inc};

    // ---- stage p0/p1: two-flop synchroniser per button ----
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= botao_raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- debounce: level flips only after DEBOUNCE_CYCLES differing samples ----
    always_ff @(posedge clock) begin
        if (reset) begin
            deb       <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (sync_p1[b] == deb[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    deb[b]    <= ~deb[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + DB_W'(1);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int               RPT_W         = $clog2(REPEAT_DELAY + REPEAT_PERIOD) + 1;
    // The counter restarts at 0 on the cycle after each pulse, so the first
    // repeat fires when it reaches REPEAT_DELAY-1 (counted from the falling
    // edge) and later repeats at REPEAT_PERIOD-2 (rise-to-rise spacing).
    localparam logic [RPT_W-1:0] ALVO_PRIMEIRO = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] ALVO_PERIODO  = RPT_W'(REPEAT_PERIOD - 2);

    logic [RPT_W-1:0] rep_cnt;
    logic             repetindo;
    logic             bloqueado;
    logic             outro_ativo;

    // The button opposite to the one that started this press.
    assign outro_ativo = i ? deb[1] : deb[0];
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    // ---- control FSM: direction is loaded in SETUP, pulse issued in PULSE ----
    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= IDLE;
            pulso     <= 1'b0;
            i         <= 1'b1;
            ocupado   <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt   <= '0;
            repetindo <= 1'b0;
            bloqueado <= 1'b0;
`endif
        end else begin
            pulso <= 1'b0;
            case (estado)
                IDLE: begin
                    if (deb == 2'b11) begin
                        // Conflicting press: wait it out without stepping.
                        estado    <= HOLD;
                        ocupado   <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        bloqueado <= 1'b1;
`endif
                    end else if (deb != 2'b00) begin
                        estado    <= SETUP;
                        i         <= deb[0];
                        ocupado   <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        bloqueado <= 1'b0;
                        repetindo <= 1'b0;
                        rep_cnt   <= '0;
`endif
                    end
                end

                SETUP: begin
                    estado <= PULSE;
                    pulso  <= 1'b1;
                end

                PULSE: begin
                    estado  <= HOLD;
`ifdef AUTO_REPEAT_EN
                    rep_cnt <= '0;
`endif
                end

                HOLD: begin
                    if (deb == 2'b00) begin
                        estado    <= IDLE;
                        ocupado   <= 1'b0;
`ifdef AUTO_REPEAT_EN
                        rep_cnt   <= '0;
                        repetindo <= 1'b0;
                        bloqueado <= 1'b0;
`endif
                    end
`ifdef AUTO_REPEAT_EN
                    else if (outro_ativo) begin
                        bloqueado <= 1'b1;
                        rep_cnt   <= '0;
                    end else if (!bloqueado) begin
                        // Only the originating button is held here.
                        if (rep_cnt == (repetindo ? ALVO_PERIODO : ALVO_PRIMEIRO)) begin
                            estado    <= PULSE;
                            pulso     <= 1'b1;
                            repetindo <= 1'b1;
                            rep_cnt   <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + RPT_W'(1);
                        end
                    end
`endif
                end

                default: begin
                    estado  <= IDLE;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_condicionador_botoes.sv
// -----------------------------------------------------------------------------
// Self-checking bench for condicionador_botoes.
// A timeline model tracks the debounced button levels and schedules the
// expected pulse / direction / busy values as edge numbers; every cycle the
// DUT outputs are compared with it, and scripted scenarios also compare with
// fixed edge numbers taken from the press-to-pulse timing.
// -----------------------------------------------------------------------------
module tb_condicionador_botoes;

    localparam int DEB  = 4;
    localparam int RDLY = 16;
    localparam int RPER = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic btn_inc = 1'b0;
    logic btn_dec = 1'b0;
    logic pulso;
    logic i;
    logic ocupado;

    int checks   = 0;
    int failures = 0;

    condicionador_botoes #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .btn_inc(btn_inc),
        .btn_dec(btn_dec),
        .pulso  (pulso),
        .i      (i),
        .ocupado(ocupado)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    int n_edge = 0;
    bit m_d1[2];
    bit m_d2[2];
    bit m_lvl[2];
    int m_run[2];
    bit m_busy;
    bit m_dir = 1'b1;
    bit m_blocked;
    int m_pulse_at   = -100;
    int m_hold_from  = 0;
    int m_next_rep   = -100;
    bit exp_pulso;
    bit exp_i = 1'b1;
    bit exp_ocup;

    task automatic model_step();
        bit raw[2];
        raw[0] = btn_inc;
        raw[1] = btn_dec;
        n_edge++;
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_run[b] = 0;
            end
            m_busy = 0; m_dir = 1; m_blocked = 0;
            m_pulse_at = -100; m_next_rep = -100;
            exp_pulso = 0; exp_i = 1; exp_ocup = 0;
            return;
        end
        // Decisions use the debounced levels as they stood before this edge.
        if (!m_busy) begin
            if (m_lvl[0] && m_lvl[1]) begin
                m_busy = 1; m_blocked = 1;
                m_hold_from = n_edge + 1;
            end else if (m_lvl[0] || m_lvl[1]) begin
                m_busy = 1; m_blocked = 0;
                m_dir = m_lvl[0];
                m_pulse_at  = n_edge + 1;
                m_hold_from = n_edge + 3;
                m_next_rep  = n_edge + 2 + RDLY;
            end
        end else if (n_edge >= m_hold_from) begin
            if (!m_lvl[0] && !m_lvl[1]) begin
                m_busy = 0;
            end
`ifdef AUTO_REPEAT_EN
            else if (m_lvl[m_dir ? 1 : 0]) begin
                m_blocked = 1;
            end else if (!m_blocked && n_edge == m_next_rep) begin
                m_pulse_at  = n_edge;
                m_hold_from = n_edge + 2;
                m_next_rep  = n_edge + RPER;
            end
`endif
        end
        exp_pulso = (n_edge == m_pulse_at);
        exp_i     = m_dir;
        exp_ocup  = m_busy;
        // Debounced levels see the raw input two edges late.
        for (int b = 0; b < 2; b++) begin
            if (m_d2[b] == m_lvl[b]) begin
                m_run[b] = 0;
            end else begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_lvl[b] = ~m_lvl[b];
                    m_run[b] = 0;
                end
            end
            m_d2[b] = m_d1[b];
            m_d1[b] = raw[b];
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1; btn_inc = 0; btn_dec = 0;
        tick();
        tick();
        checks++;
        if ({pulso, i, ocupado} !== 3'b010) begin
            failures++;
            $display("FAIL reset_values got pulso/i/ocupado=%b%b%b expected 010", pulso, i, ocupado);
        end
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                failures++;
                $display("FAIL reset_idle edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
            end
        end
    endtask

    task automatic test_single_inc();
        btn_inc = 1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                failures++;
                $display("FAIL inc_model edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
            end
            checks++;
            if (pulso !== (k == DEB + 4)) begin
                failures++;
                $display("FAIL inc_pulse_edge k=%0d got pulso=%b expected %b", k, pulso, (k == DEB + 4));
            end
        end
        btn_inc = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                failures++;
                $display("FAIL inc_release_model edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
            end
            checks++;
            if (ocupado !== (k <= 6)) begin
                failures++;
                $display("FAIL inc_release_busy k=%0d got ocupado=%b expected %b", k, ocupado, (k <= 6));
            end
        end
    endtask

    task automatic test_conflict();
        btn_inc = 1; btn_dec = 1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                failures++;
                $display("FAIL conflict_model edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
            end
            checks++;
            if (pulso !== 1'b0 || i !== 1'b1) begin
                failures++;
                $display("FAIL conflict_no_step k=%0d got pulso=%b i=%b expected pulso=0 i=1", k, pulso, i);
            end
        end
        btn_inc = 0; btn_dec = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                failures++;
                $display("FAIL conflict_release edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
            end
        end
        checks++;
        if (ocupado !== 1'b0) begin
            failures++;
            $display("FAIL conflict_idle got ocupado=%b expected 0", ocupado);
        end
    endtask

    task automatic test_dec();
        btn_dec = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                failures++;
                $display("FAIL dec_model edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
            end
            checks++;
            if (pulso !== (k == DEB + 4) || i !== (k < DEB + 3)) begin
                failures++;
                $display("FAIL dec_timing k=%0d got pulso=%b i=%b expected pulso=%b i=%b", k, pulso, i, (k == DEB + 4), (k < DEB + 3));
            end
        end
        btn_dec = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (pulso !== 1'b0 || i !== 1'b0) begin
                failures++;
                $display("FAIL dec_release k=%0d got pulso=%b i=%b expected pulso=0 i=0", k, pulso, i);
            end
        end
    endtask

    task automatic test_glitch();
        bit pat[$];
        for (int w = 1; w <= 3; w++) begin
            for (int k = 0; k < w; k++) pat.push_back(1'b1);
            for (int k = 0; k < 8; k++) pat.push_back(1'b0);
        end
        for (int k = 0; k < 6; k++) pat.push_back(((k / 2) % 2) == 0);
        for (int k = 0; k < 10; k++) pat.push_back(1'b0);
        foreach (pat[k]) begin
            btn_inc = pat[k];
            tick();
            checks++;
            if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                failures++;
                $display("FAIL glitch_model edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
            end
            checks++;
            if (pulso !== 1'b0 || ocupado !== 1'b0) begin
                failures++;
                $display("FAIL glitch_quiet step=%0d got pulso=%b ocupado=%b expected 0 0", k, pulso, ocupado);
            end
        end
        btn_inc = 0;
    endtask

    task automatic test_reset_mid_pulse();
        btn_inc = 1;
        for (int k = 1; k <= DEB + 4; k++) begin
            tick();
            checks++;
            if (pulso !== (k == DEB + 4)) begin
                failures++;
                $display("FAIL midrst_first_pulse k=%0d got pulso=%b expected %b", k, pulso, (k == DEB + 4));
            end
        end
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if ({pulso, i, ocupado} !== 3'b010) begin
            failures++;
            $display("FAIL midrst_values got pulso/i/ocupado=%b%b%b expected 010", pulso, i, ocupado);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                failures++;
                $display("FAIL midrst_model edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
            end
            checks++;
            if (pulso !== (k == DEB + 4)) begin
                failures++;
                $display("FAIL midrst_repress k=%0d got pulso=%b expected %b", k, pulso, (k == DEB + 4));
            end
        end
        btn_inc = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            checks++;
            if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                failures++;
                $display("FAIL midrst_release edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
            end
        end
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        btn_inc = 1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            checks++;
            if (pulso !== (k inside {8, 25, 33, 41, 49, 57})) begin
                failures++;
                $display("FAIL repeat_edges k=%0d got pulso=%b expected %b", k, pulso, (k inside {8, 25, 33, 41, 49, 57}));
            end
            checks++;
            if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                failures++;
                $display("FAIL repeat_model edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
            end
        end
        btn_inc = 0;
        for (int k = 61; k <= 80; k++) begin
            tick();
            checks++;
            if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                failures++;
                $display("FAIL repeat_release edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
            end
            if (k >= 67) begin
                checks++;
                if (pulso !== 1'b0) begin
                    failures++;
                    $display("FAIL repeat_stopped k=%0d got pulso=%b expected 0", k, pulso);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        bit prev_p;
        bit prev_i;
        int len;
        int choice;
        bit a;
        bit d;
        prev_p = pulso;
        prev_i = i;
        for (int seg = 0; seg < 200; seg++) begin
            len    = $urandom_range(1, 14);
            choice = $urandom_range(0, 7);
            a = (choice <= 2) || (choice == 6);
            d = (choice >= 3 && choice <= 5) || (choice == 6);
            reset = ($urandom_range(0, 29) == 0);
            for (int k = 0; k < len; k++) begin
                btn_inc = ($urandom_range(0, 9) == 0) ? ~a : a;
                btn_dec = d;
                tick();
                reset = 0;
                checks++;
                if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                    failures++;
                    $display("FAIL random_model edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
                end
                checks++;
                if (pulso === 1'b1 && (prev_p === 1'b1 || i !== prev_i)) begin
                    failures++;
                    $display("FAIL random_pulse_guard edge=%0d got prev_pulso=%b i=%b prev_i=%b expected isolated pulse with stable i", n_edge, prev_p, i, prev_i);
                end
                prev_p = pulso;
                prev_i = i;
            end
        end
        btn_inc = 0;
        btn_dec = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++;
            if ({pulso, i, ocupado} !== {exp_pulso, exp_i, exp_ocup}) begin
                failures++;
                $display("FAIL random_drain edge=%0d got %b%b%b expected %b%b%b", n_edge, pulso, i, ocupado, exp_pulso, exp_i, exp_ocup);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_conflict();
        test_dec();
        test_glitch();
        test_reset_mid_pulse();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
